// File: rtl/digit_entry_pkg.sv
// digit_entry_pkg: shared types and widths for the digit entry controller.
// Provides the FSM state enum and the digit/select/depth constants.
package digit_entry_pkg;
    localparam int DIGIT_W = 3;
    localparam int SEL_W = 2;
    localparam int NUM_DIGITS = 4;
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects one raw push button.
// Ports: clk, reset (sync, active-high), btn (raw async input),
//        evt (one-cycle registered pulse on each accepted press).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES);
    logic [1:0] sync;
    logic level, level_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            level <= 1'b0;
            level_q <= 1'b0;
            evt <= 1'b0;
            cnt <= '0;
        end else begin
            sync <= {sync[0], btn};
            level_q <= level;
            evt <= level & ~level_q;
            // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle;
            // the counter then parks at terminal count until the two agree again.
            if (sync[1] == level) begin
                cnt <= '0;
            end else begin
                if (cnt == LAST) level <= sync[1];
                if (cnt != TERM) cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: turns enter/clear button presses into digit register writes.
// Ports: clk, reset (sync, active-high), sw_num (digit value switches),
//        btn_enter / btn_clear (raw buttons), num / sel / wr (registered write
//        port), busy (clear burst active), cursor (next enter position).
module digit_entry_ctrl
    import digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] sw_num,
    input  logic               btn_enter,
    input  logic               btn_clear,
    output logic [DIGIT_W-1:0] num,
    output logic [SEL_W-1:0]   sel,
    output logic               wr,
    output logic               busy,
    output logic [SEL_W-1:0]   cursor
);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);
    logic ent_evt, clr_evt;
    state_t state, state_n;
    logic [SEL_W-1:0] cursor_n, idx, idx_n, sel_n;
    logic [DIGIT_W-1:0] num_n;
    logic wr_n, busy_n;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk), .reset(reset), .btn(btn_enter), .evt(ent_evt)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .reset(reset), .btn(btn_clear), .evt(clr_evt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cursor <= '0;
            idx <= '0;
            num <= '0;
            sel <= '0;
            wr <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            cursor <= cursor_n;
            idx <= idx_n;
            num <= num_n;
            sel <= sel_n;
            wr <= wr_n;
            busy <= busy_n;
        end
    end

    // The first write of either kind is launched on the IDLE transition so wr
    // appears one cycle after the event; events outside IDLE are ignored.
    always_comb begin
        state_n = state;
        cursor_n = cursor;
        idx_n = idx;
        num_n = num;
        sel_n = sel;
        wr_n = 1'b0;
        busy_n = 1'b0;
        case (state)
            IDLE: begin
                if (clr_evt) begin
                    state_n = CLEAR;
                    wr_n = 1'b1;
                    busy_n = 1'b1;
                    num_n = '0;
                    sel_n = '0;
                    idx_n = SEL_W'(1);
                end else if (ent_evt) begin
                    state_n = WRITE;
                    wr_n = 1'b1;
                    num_n = sw_num;
                    sel_n = cursor;
                end
            end
            WRITE: begin
                cursor_n = cursor + 1'b1;
                state_n = IDLE;
            end
            CLEAR: begin
                wr_n = 1'b1;
                busy_n = 1'b1;
                sel_n = idx;
                idx_n = idx + 1'b1;
                if (idx == LAST_SEL) begin
                    cursor_n = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/digit_entry_ctrl.md
# digit_entry_ctrl

Front-end entry controller for the four-digit seven-segment display path. It conditions raw push-button inputs and turns operator presses into single-cycle register writes (`num`, `sel`, `wr`) for the digit register stage. Each press writes the current switch value into the next digit position, with the position auto-advancing. A clear button writes zero into all four digits in a burst.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); minimum 1.

Ports:
- `clk`, in, 1: 50 MHz system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `sw_num`, in, 3: slide-switch digit value (0–7); treated as quasi-static and not debounced.
- `btn_enter`, in, 1: raw asynchronous push button, active-high.
- `btn_clear`, in, 1: raw asynchronous push button, active-high.
- `num`, out, 3: digit value to write.
- `sel`, out, 2: target digit position (0 = leftmost).
- `wr`, out, 1: write strobe, high for exactly one cycle per write.
- `busy`, out, 1: high while a clear burst is in progress.
- `cursor`, out, 2: next position the enter button will write.

## Operation
- **Conditioning** (per button): 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any cycle where the two agree resets the counter to 0.
- **Events**: a rising edge of the debounced level produces a registered one-cycle event pulse.
  - Releases produce no event.
  - A held button produces no repeats.
- **FSM states**: IDLE, WRITE, CLEAR.
  - IDLE + enter event → WRITE. `num` ← `sw_num` captured at the event cycle, `sel` ← `cursor`.
  - WRITE: `wr` = 1 for one cycle, `cursor` ← `cursor` + 1 mod 4 (3 wraps to 0), then → IDLE.
  - IDLE + clear event → CLEAR. Four consecutive cycles with `wr` = 1, `num` = 0, `sel` = 0, 1, 2, 3. `busy` = 1 for those four cycles. On the last cycle `cursor` ← 0, then → IDLE.
- **Simultaneous events**: if enter and clear events occur in the same IDLE cycle, clear wins and the enter event is discarded.
- **Events outside IDLE**: events arriving in WRITE or CLEAR are dropped, never queued.
- **Output hold**: `num` and `sel` hold their last written values between writes. `wr` is low outside write cycles.
- **Width rules**: `cursor` and `sel` are 2-bit and wrap naturally. The debounce counter is sized `$clog2(DEBOUNCE_CYCLES+1)` and saturates at terminal count.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- **Reset** (applied at the clock edge):
  - `num` = 0, `sel` = 0, `wr` = 0, `busy` = 0, `cursor` = 0, FSM = IDLE.
  - Synchronizers, debounced levels, counters and event registers all = 0.
- **Enter latency**: raw `btn_enter` is stable high from sampling edge 1.
  - Synchronized high after edge 2.
  - Debounced high after edge 2 + `DEBOUNCE_CYCLES`.
  - Event pulse after edge 3 + `DEBOUNCE_CYCLES`.
  - `wr` high for the single cycle after edge 4 + `DEBOUNCE_CYCLES`.
- **Clear latency**: same path as enter. The first clear write (`sel` = 0) appears in the same relative cycle as an enter write would. The four writes follow back-to-back, with no gaps.
- **Reset mid-CLEAR**: burst aborts at that edge, `wr` = 0 and `busy` = 0 from the next cycle. Already-written digits stay cleared downstream.
- **Reset mid-bounce**: counters cleared; a still-pressed button must re-qualify for the full `DEBOUNCE_CYCLES` after reset deasserts.

## Structure
- **Package `digit_entry_pkg`**:
  - FSM state enum (IDLE, WRITE, CLEAR).
  - Constants `DIGIT_W` = 3, `SEL_W` = 2, `NUM_DIGITS` = 4.
- **Sub-module `button_conditioner`**: synchronizer, debouncer and rising-edge pulse; parameterized by `DEBOUNCE_CYCLES`. Instantiated once per button.
- **Top**: holds the FSM, cursor, clear-burst index and output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset**: assert `reset` with buttons idle → all outputs 0 on the following cycle, `cursor` = 0.
- **Sequential entry**: three clean presses with `sw_num` = 5, 2, 7 → three single-cycle `wr` pulses with (`sel`, `num`) = (0, 5), (1, 2), (2, 7); final `cursor` = 3. Each `wr` lands exactly 4 + 4 edges after the raw press.
- **Bounce rejection**: `btn_enter` toggled high/low every 2 cycles for 20 cycles, then low → no `wr`, `cursor` unchanged.
- **Cursor wrap and hold**: five presses, the first held 100 cycles → exactly five `wr` pulses with `sel` = 0, 1, 2, 3, 0.
- **Clear burst**: with `cursor` = 2, press clear → four consecutive `wr` cycles with `num` = 0 and `sel` = 0, 1, 2, 3; `busy` high for exactly those 4 cycles; `cursor` = 0 afterwards.
- **Collisions and abort**:
  - Enter and clear debounced in the same cycle → clear burst only, no enter write.
  - `reset` on the second clear write → `wr` = 0 and `busy` = 0 the next cycle.
